pc_sequencer: RTL and testbench



---
 rtl/pc_sequencer.sv | 125 ++++++++++++
 tb/tb_pc_sequencer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the program counter and sequences instruction fetch.
// Advances by 4 on each accepted fetch, applies branch/jump redirects with
// optional MIPS delay-slot semantics, honours memory backpressure and stalls,
// and traps (sticky) on a misaligned redirect target.
//
// Handshake: fetch_valid/fetch_ready form a strict valid/ready pair. A fetch
// is accepted on a rising edge where both are 1. While fetch_valid is high and
// not yet accepted, pc does not change, so the request stays stable. The only
// exceptions are a redirect without delay slot, which abandons the in-flight
// fetch, and a misaligned redirect, which freezes the sequencer in FAULT.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          DELAY_SLOT   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        fetch_ready,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_valid,
  output logic        flush,
  output logic        fault,
  output logic [15:0] redirect_count,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_RUN   = 2'd1,
    S_SLOT  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pending_q, pending_d;
  logic        flush_q, flush_d;
  logic [15:0] count_q, count_d;
  logic        count_inc;
  logic        accept;
  logic        misaligned;

  assign fetch_valid = ((state_q == S_RUN) || (state_q == S_SLOT)) && !stall;
  assign accept      = fetch_valid && fetch_ready;
  assign misaligned  = (redirect_target[1:0] != 2'b00);

  assign pc             = pc_q;
  assign pc_plus4       = pc_q + 32'd4;
  assign flush          = flush_q;
  assign fault          = (state_q == S_FAULT);
  assign redirect_count = count_q;
  assign dbg_state_o    = state_q;

  // Next-state logic: priority is misaligned fault > redirect > stall > accept.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pending_d = pending_q;
    flush_d   = 1'b0;
    count_inc = 1'b0;
    case (state_q)
      S_BOOT: begin
        state_d = S_RUN;
      end
      S_RUN: begin
        if (redirect_valid) begin
          if (misaligned) begin
            state_d = S_FAULT;
          end else if (DELAY_SLOT == 0) begin
            // Redirect wins regardless of stall/accept; in-flight fetch dropped.
            pc_d      = redirect_target;
            flush_d   = 1'b1;
            count_inc = 1'b1;
          end else if (accept) begin
            // The delay-slot instruction is the one fetched this cycle.
            pc_d      = redirect_target;
            count_inc = 1'b1;
          end else begin
            // Delay slot not yet fetched: park the target until it is.
            pending_d = redirect_target;
            state_d   = S_SLOT;
          end
        end else if (accept) begin
          pc_d = pc_q + 32'd4;
        end
      end
      S_SLOT: begin
        // Redirects here are ignored: the first redirect wins.
        if (accept) begin
          pc_d      = pending_q;
          count_inc = 1'b1;
          state_d   = S_RUN;
        end
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: begin
        state_d = S_FAULT;
      end
    endcase
    count_d = (count_inc && (count_q != 16'hFFFF)) ? count_q + 16'd1 : count_q;
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_BOOT;
      pc_q      <= RESET_VECTOR;
      pending_q <= 32'h0000_0000;
      flush_q   <= 1'b0;
      count_q   <= 16'h0000;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pending_q <= pending_d;
      flush_q   <= flush_d;
      count_q   <= count_d;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer. Two instances share all inputs: one with
// the delay slot enabled (u_ds1) and one without (u_ds0), both starting at
// 0x400. Inputs change 2 ns after a rising edge; outputs are checked there.
module tb_pc_sequencer;

  localparam logic [31:0] RV = 32'h0000_0400;
  localparam logic [1:0]  ST_BOOT  = 2'd0;
  localparam logic [1:0]  ST_RUN   = 2'd1;
  localparam logic [1:0]  ST_SLOT  = 2'd2;
  localparam logic [1:0]  ST_FAULT = 2'd3;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        fetch_ready;

  logic [31:0] pc1, pc_plus4_1, pc0, pc_plus4_0;
  logic        fv1, flush1, fault1, fv0, flush0, fault0;
  logic [15:0] cnt1, cnt0;
  logic [1:0]  st1, st0;

  int checks = 0;
  int errors = 0;

  // Clock: 10 ns period.
  always #5 clk = ~clk;

  pc_sequencer #(.RESET_VECTOR(RV), .DELAY_SLOT(1)) u_ds1 (
    .clk(clk), .rst(rst), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .fetch_ready(fetch_ready),
    .pc(pc1), .pc_plus4(pc_plus4_1), .fetch_valid(fv1), .flush(flush1),
    .fault(fault1), .redirect_count(cnt1), .dbg_state_o(st1)
  );

  pc_sequencer #(.RESET_VECTOR(RV), .DELAY_SLOT(0)) u_ds0 (
    .clk(clk), .rst(rst), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .fetch_ready(fetch_ready),
    .pc(pc0), .pc_plus4(pc_plus4_0), .fetch_valid(fv0), .flush(flush0),
    .fault(fault0), .redirect_count(cnt0), .dbg_state_o(st0)
  );

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Reset both instances; returns with state BOOT and rst released.
  task automatic do_reset();
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0;
    redirect_target = 32'h0; fetch_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  // From RUN with accept: move both instances' pc to addr, then idle.
  task automatic go_to(input logic [31:0] addr);
    fetch_ready = 1'b1; redirect_valid = 1'b1; redirect_target = addr;
    tick();
    redirect_valid = 1'b0; fetch_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0;
    redirect_target = 32'h0; fetch_ready = 1'b0;
    #3;
    checks++; if (pc1 !== RV) begin errors++; $display("FAIL reset_pc1: got %h expected %h", pc1, RV); end
    checks++; if (pc0 !== RV) begin errors++; $display("FAIL reset_pc0: got %h expected %h", pc0, RV); end
    checks++; if (fv1 !== 1'b0) begin errors++; $display("FAIL reset_fv: got %b expected 0", fv1); end
    checks++; if ({flush1, flush0, fault1, fault0} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b expected 0000", {flush1, flush0, fault1, fault0}); end
    checks++; if (cnt1 !== 16'h0) begin errors++; $display("FAIL reset_count: got %h expected 0000", cnt1); end
    checks++; if (st1 !== ST_BOOT) begin errors++; $display("FAIL reset_state: got %0d expected %0d", st1, ST_BOOT); end
    tick();
    rst = 1'b0; fetch_ready = 1'b1;
    #1;
    checks++; if (fv1 !== 1'b0) begin errors++; $display("FAIL boot_fv: got %b expected 0", fv1); end
    tick();
    checks++; if (pc1 !== 32'h400 || fv1 !== 1'b1) begin errors++; $display("FAIL seq0: got pc %h fv %b expected 400 1", pc1, fv1); end
    tick();
    checks++; if (pc1 !== 32'h404) begin errors++; $display("FAIL seq1: got %h expected 404", pc1); end
    tick();
    checks++; if (pc1 !== 32'h408 || pc0 !== 32'h408) begin errors++; $display("FAIL seq2: got %h/%h expected 408", pc1, pc0); end
  endtask

  task automatic test_backpressure();
    tick(); tick();
    checks++; if (pc1 !== 32'h410) begin errors++; $display("FAIL bp_start: got %h expected 410", pc1); end
    fetch_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (pc1 !== 32'h410 || fv1 !== 1'b1) begin errors++; $display("FAIL bp_hold%0d: got pc %h fv %b expected 410 1", i, pc1, fv1); end
    end
    stall = 1'b1;
    #1;
    checks++; if (fv1 !== 1'b0 || fv0 !== 1'b0) begin errors++; $display("FAIL stall_fv: got %b/%b expected 0", fv1, fv0); end
    fetch_ready = 1'b1;
    tick();
    checks++; if (pc1 !== 32'h410) begin errors++; $display("FAIL stall_hold: got %h expected 410", pc1); end
    stall = 1'b0;
    tick();
    checks++; if (pc1 !== 32'h414) begin errors++; $display("FAIL bp_release: got %h expected 414", pc1); end
    fetch_ready = 1'b0;
  endtask

  task automatic test_delay_slot();
    do_reset(); tick();
    go_to(32'h500);
    fetch_ready = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h800;
    tick();
    redirect_valid = 1'b0; fetch_ready = 1'b0;
    checks++; if (pc1 !== 32'h800 || flush1 !== 1'b0 || cnt1 !== 16'd2) begin errors++; $display("FAIL ds_accept: got pc %h flush %b cnt %0d expected 800 0 2", pc1, flush1, cnt1); end
    go_to(32'h500);
    redirect_valid = 1'b1; redirect_target = 32'h800;
    tick();
    checks++; if (st1 !== ST_SLOT || pc1 !== 32'h500) begin errors++; $display("FAIL ds_slot: got st %0d pc %h expected 2 500", st1, pc1); end
    redirect_target = 32'h900;
    tick();
    checks++; if (st1 !== ST_SLOT || pc1 !== 32'h500 || cnt1 !== 16'd3 || fv1 !== 1'b1) begin errors++; $display("FAIL ds_slot_hold: got st %0d pc %h cnt %0d fv %b expected 2 500 3 1", st1, pc1, cnt1, fv1); end
    fetch_ready = 1'b1;
    tick();
    redirect_valid = 1'b0; fetch_ready = 1'b0;
    checks++; if (pc1 !== 32'h800 || st1 !== ST_RUN || cnt1 !== 16'd4 || flush1 !== 1'b0) begin errors++; $display("FAIL ds_slot_exit: got pc %h st %0d cnt %0d flush %b expected 800 1 4 0", pc1, st1, cnt1, flush1); end
    tick();
    checks++; if (pc1 !== 32'h800) begin errors++; $display("FAIL ds_second_ignored: got %h expected 800", pc1); end
  endtask

  task automatic test_no_delay_slot();
    do_reset(); tick();
    go_to(32'h600);
    stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h100;
    tick();
    redirect_valid = 1'b0;
    checks++; if (pc0 !== 32'h100 || flush0 !== 1'b1 || cnt0 !== 16'd2) begin errors++; $display("FAIL nds_redirect: got pc %h flush %b cnt %0d expected 100 1 2", pc0, flush0, cnt0); end
    checks++; if (st1 !== ST_SLOT || pc1 !== 32'h600 || flush1 !== 1'b0) begin errors++; $display("FAIL ds_stall_slot: got st %0d pc %h flush %b expected 2 600 0", st1, pc1, flush1); end
    tick();
    checks++; if (flush0 !== 1'b0 || pc0 !== 32'h100) begin errors++; $display("FAIL nds_flush_pulse: got flush %b pc %h expected 0 100", flush0, pc0); end
    stall = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset(); tick();
    fetch_ready = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h1000;
    tick();
    redirect_target = 32'h2000;
    tick();
    redirect_valid = 1'b0; fetch_ready = 1'b0;
    checks++; if (pc1 !== 32'h2000 || cnt1 !== 16'd2) begin errors++; $display("FAIL b2b_ds1: got pc %h cnt %0d expected 2000 2", pc1, cnt1); end
    checks++; if (pc0 !== 32'h2000 || flush0 !== 1'b1 || cnt0 !== 16'd2) begin errors++; $display("FAIL b2b_ds0: got pc %h flush %b cnt %0d expected 2000 1 2", pc0, flush0, cnt0); end
  endtask

  task automatic test_fault();
    do_reset(); tick();
    fetch_ready = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h802;
    tick();
    checks++; if (fault1 !== 1'b1 || st1 !== ST_FAULT || pc1 !== RV || fv1 !== 1'b0) begin errors++; $display("FAIL fault_ds1: got fault %b st %0d pc %h fv %b expected 1 3 400 0", fault1, st1, pc1, fv1); end
    checks++; if (fault0 !== 1'b1 || flush0 !== 1'b0 || pc0 !== RV) begin errors++; $display("FAIL fault_ds0: got fault %b flush %b pc %h expected 1 0 400", fault0, flush0, pc0); end
    redirect_target = 32'h200;
    for (int i = 0; i < 3; i++) tick();
    checks++; if (fault1 !== 1'b1 || pc1 !== RV || fv1 !== 1'b0 || cnt1 !== 16'd0 || pc0 !== RV) begin errors++; $display("FAIL fault_frozen: got fault %b pc %h fv %b cnt %0d pc0 %h expected 1 400 0 0 400", fault1, pc1, fv1, cnt1, pc0); end
    redirect_valid = 1'b0;
    rst = 1'b1;
    #1;
    checks++; if (fault1 !== 1'b0 || fault0 !== 1'b0 || pc1 !== RV || st1 !== ST_BOOT) begin errors++; $display("FAIL fault_reset: got fault %b/%b pc %h st %0d expected 0 400 0", fault1, fault0, pc1, st1); end
    tick();
    rst = 1'b0; fetch_ready = 1'b0;
  endtask

  task automatic test_wrap();
    do_reset(); tick();
    go_to(32'hFFFF_FFFC);
    checks++; if (pc1 !== 32'hFFFF_FFFC || pc_plus4_1 !== 32'h0) begin errors++; $display("FAIL wrap_plus4: got pc %h plus4 %h expected fffffffc 0", pc1, pc_plus4_1); end
    fetch_ready = 1'b1;
    tick();
    fetch_ready = 1'b0;
    checks++; if (pc1 !== 32'h0 || pc0 !== 32'h0 || pc_plus4_1 !== 32'h4) begin errors++; $display("FAIL wrap_pc: got %h/%h plus4 %h expected 0 4", pc1, pc0, pc_plus4_1); end
  endtask

  task automatic test_saturation();
    do_reset(); tick();
    fetch_ready = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h400;
    repeat (65534) tick();
    checks++; if (cnt1 !== 16'hFFFE || cnt0 !== 16'hFFFE) begin errors++; $display("FAIL sat_fffe: got %h/%h expected fffe", cnt1, cnt0); end
    tick();
    checks++; if (cnt1 !== 16'hFFFF || cnt0 !== 16'hFFFF) begin errors++; $display("FAIL sat_ffff: got %h/%h expected ffff", cnt1, cnt0); end
    tick(); tick();
    checks++; if (cnt1 !== 16'hFFFF || cnt0 !== 16'hFFFF) begin errors++; $display("FAIL sat_hold: got %h/%h expected ffff", cnt1, cnt0); end
    redirect_valid = 1'b0; fetch_ready = 1'b0;
  endtask

  task automatic test_reset_in_slot();
    do_reset(); tick();
    redirect_valid = 1'b1; redirect_target = 32'h700;
    tick();
    redirect_valid = 1'b0;
    checks++; if (st1 !== ST_SLOT) begin errors++; $display("FAIL rslot_enter: got st %0d expected 2", st1); end
    rst = 1'b1;
    #1;
    checks++; if (pc1 !== RV || st1 !== ST_BOOT) begin errors++; $display("FAIL rslot_reset: got pc %h st %0d expected 400 0", pc1, st1); end
    tick();
    rst = 1'b0; fetch_ready = 1'b1;
    tick(); tick();
    fetch_ready = 1'b0;
    checks++; if (pc1 !== 32'h404 || st1 !== ST_RUN || cnt1 !== 16'd0) begin errors++; $display("FAIL rslot_discard: got pc %h st %0d cnt %0d expected 404 1 0", pc1, st1, cnt1); end
  endtask

  initial begin
    test_reset();
    test_backpressure();
    test_delay_slot();
    test_no_delay_slot();
    test_back_to_back();
    test_fault();
    test_wrap();
    test_saturation();
    test_reset_in_slot();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
